hcv_fill: RTL

- Rectangle-fill engine for the 1024x768 high-colour framebuffer.
- CPU programs origin, size and 15-bit colour through a small register port, then starts a fill.
- The block acts as bus master on the framebuffer bus port (stb/we/addr/data/ack), sitting directly upstream of the video controller and issuing one pixel write per access.
- The CPU and the fill engine share the framebuffer port through the existing bus arbitration. While busy, the fill engine owns the port.

---
 rtl/hcv_pkg.sv | 31 +++
 rtl/hcv_fill_regs.sv | 109 ++++++++++
 rtl/hcv_fill.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hcv_pkg.sv
// hcv_pkg: constants shared by the hcv_fill rectangle-fill engine.
//   - framebuffer geometry (SCR_W x SCR_H)
//   - CPU register offsets and CTRL bit positions
//   - fill FSM state encoding
package hcv_pkg;

    localparam int SCR_W = 1024;
    localparam int SCR_H = 768;

    localparam logic [1:0] REG_ORG   = 2'd0;
    localparam logic [1:0] REG_SIZE  = 2'd1;
    localparam logic [1:0] REG_COLOR = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;
    // CTRL read bits
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_IRQ   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_GAP,
        ST_GAP_LAST
    } fill_st_t;

endpackage

// File: rtl/hcv_fill_regs.sv
// hcv_fill_regs: CPU register file for the fill engine.
//   clk, rst          clock, synchronous active-high reset
//   stb/we/addr       CPU access (stb held until ack)
//   data_in/data_out  CPU write / read data (data_out valid while ack=1)
//   ack               one-cycle registered acknowledge
//   busy/done/irq_pend  status from the engine, visible in CTRL
//   start/clr_done    one-cycle CTRL command pulses (high during the ack cycle)
//   x0/y0/w/h/colour  working geometry, latched from the CPU copies on an
//                     accepted start so mid-fill writes cannot disturb a fill
module hcv_fill_regs
    import hcv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        busy,
    input  logic        done,
    input  logic        irq_pend,
    output logic        start,
    output logic        clr_done,
    output logic [9:0]  x0,
    output logic [9:0]  y0,
    output logic [10:0] w,
    output logic [9:0]  h,
    output logic [14:0] colour
);

    logic [9:0]  cfg_x0;
    logic [9:0]  cfg_y0;
    logic [10:0] cfg_w;
    logic [9:0]  cfg_h;
    logic [14:0] cfg_colour;
    logic [31:0] rd_mux;
    logic        acc;

    // A new access is taken only when ack is low, so the held stb is not
    // seen twice.
    assign acc = stb && !ack;

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_ORG:   begin rd_mux[9:0] = cfg_x0; rd_mux[25:16] = cfg_y0; end
            REG_SIZE:  begin rd_mux[10:0] = cfg_w; rd_mux[25:16] = cfg_h; end
            REG_COLOR: rd_mux[14:0] = cfg_colour;
            default: begin
                rd_mux[CTRL_BUSY] = busy;
                rd_mux[CTRL_DONE] = done;
                rd_mux[CTRL_IRQ]  = irq_pend;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack        <= 1'b0;
            data_out   <= '0;
            start      <= 1'b0;
            clr_done   <= 1'b0;
            cfg_x0     <= '0;
            cfg_y0     <= '0;
            cfg_w      <= '0;
            cfg_h      <= '0;
            cfg_colour <= '0;
            x0         <= '0;
            y0         <= '0;
            w          <= '0;
            h          <= '0;
            colour     <= '0;
        end else begin
            ack      <= acc;
            data_out <= '0;
            start    <= 1'b0;
            clr_done <= 1'b0;
            if (acc) begin
                if (we) begin
                    case (addr)
                        REG_ORG:   begin cfg_x0 <= data_in[9:0];  cfg_y0 <= data_in[25:16]; end
                        REG_SIZE:  begin cfg_w  <= data_in[10:0]; cfg_h  <= data_in[25:16]; end
                        REG_COLOR: cfg_colour <= data_in[14:0];
                        default: begin
                            start    <= data_in[CTRL_START];
                            clr_done <= data_in[CTRL_CLR];
                        end
                    endcase
                end else begin
                    data_out <= rd_mux;
                end
            end
            // Same condition the FSM uses to leave IDLE.
            if (start && !busy) begin
                x0     <= cfg_x0;
                y0     <= cfg_y0;
                w      <= cfg_w;
                h      <= cfg_h;
                colour <= cfg_colour;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{data_in[31:26], data_in[15]};

endmodule

// File: rtl/hcv_fill.sv
// hcv_fill: rectangle-fill engine for the 1024x768 high-colour framebuffer.
//   clk, rst          clock, synchronous active-high reset
//   stb/we/addr/data_in/data_out/ack   CPU register port (ORG, SIZE, COLOR, CTRL)
//   fb_stb/fb_we/fb_addr/fb_data/fb_ack framebuffer master port, one pixel
//                     per access, fb_addr = {y, x}, fb_data = {0, colour}
//   irq               fill-complete interrupt level
// Build option HCV_FILL_IRQ_EN: when defined, irq is set when done rises and
// cleared by a CTRL clear-done write; otherwise irq is tied to 0.
module hcv_fill
    import hcv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        fb_stb,
    output logic        fb_we,
    output logic [19:0] fb_addr,
    output logic [15:0] fb_data,
    input  logic        fb_ack,
    output logic        irq
);

    localparam logic [11:0] W_LIM = 12'(SCR_W);
    localparam logic [11:0] H_LIM = 12'(SCR_H);

    fill_st_t    state;
    logic        busy;
    logic        done;
    logic        start;
    logic        clr_done;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [10:0] w;
    logic [9:0]  h;
    logic [14:0] colour;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic [10:0] x_end;
    logic [10:0] y_end;

    assign busy    = (state != ST_IDLE);
    assign fb_addr = {y_cnt, x_cnt};

    hcv_fill_regs u_regs (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .irq_pend (irq),
        .start    (start),
        .clr_done (clr_done),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .colour   (colour)
    );

    // Clip bounds: sums are carried at 12 bits so x0+w cannot wrap before
    // the min(); the clipped result always fits in 11 bits.
    logic [11:0] x_sum, y_sum;
    logic [10:0] x_lim, y_lim;
    logic        empty;
    logic [10:0] x_nxt, y_nxt;
    logic        more_x, more_y;
    logic        set_done;

    always_comb begin
        x_sum    = {2'b00, x0} + {1'b0, w};
        y_sum    = {2'b00, y0} + {2'b00, h};
        x_lim    = (x_sum > W_LIM) ? W_LIM[10:0] : x_sum[10:0];
        y_lim    = (y_sum > H_LIM) ? H_LIM[10:0] : y_sum[10:0];
        empty    = (w == '0) || (h == '0) ||
                   ({1'b0, x0} >= W_LIM[10:0]) || ({1'b0, y0} >= H_LIM[10:0]);
        x_nxt    = {1'b0, x_cnt} + 11'd1;
        y_nxt    = {1'b0, y_cnt} + 11'd1;
        more_x   = (x_nxt < x_end);
        more_y   = (y_nxt < y_end);
        set_done = ((state == ST_SETUP) && empty) ||
                   ((state == ST_WRITE) && fb_ack && !more_x && !more_y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            x_cnt   <= '0;
            y_cnt   <= '0;
            x_end   <= '0;
            y_end   <= '0;
            fb_stb  <= 1'b0;
            fb_we   <= 1'b0;
            fb_data <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_SETUP;
                ST_SETUP: begin
                    x_end   <= x_lim;
                    y_end   <= y_lim;
                    x_cnt   <= x0;
                    y_cnt   <= y0;
                    fb_data <= {1'b0, colour};
                    if (empty) begin
                        state <= ST_IDLE;
                    end else begin
                        state  <= ST_WRITE;
                        fb_stb <= 1'b1;
                        fb_we  <= 1'b1;
                    end
                end
                ST_WRITE: if (fb_ack) begin
                    fb_stb <= 1'b0;
                    fb_we  <= 1'b0;
                    if (more_x) begin
                        x_cnt <= x_nxt[9:0];
                        state <= ST_GAP;
                    end else if (more_y) begin
                        x_cnt <= x0;
                        y_cnt <= y_nxt[9:0];
                        state <= ST_GAP;
                    end else begin
                        state <= ST_GAP_LAST;
                    end
                end
                // The port keeps ack high for a second cycle; skip it.
                ST_GAP: begin
                    fb_stb <= 1'b1;
                    fb_we  <= 1'b1;
                    state  <= ST_WRITE;
                end
                ST_GAP_LAST: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            // Completion has priority over a same-cycle clear.
            if (set_done)      done <= 1'b1;
            else if (clr_done) done <= 1'b0;
        end
    end

`ifdef HCV_FILL_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (rst)                   irq_q <= 1'b0;
        else if (set_done && !done) irq_q <= 1'b1;
        else if (clr_done)         irq_q <= 1'b0;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
